npc_gen: RTL

//  Fetch-PC generator: first front-end stage, directly upstream of the IFU fetch buffer.

---
 rtl/npc_gen_pkg.sv | 35 +++
 rtl/npc_gen_if.sv | 29 ++
 rtl/npc_btb.sv | 81 ++++++++
 rtl/npc_gen.sv | 90 +++++++++
 4 files changed

// File: rtl/npc_gen_pkg.sv
// Shared types and constants for the fetch-PC generator and its group BTB.
package npc_gen_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h1C00_0000;
    localparam int          BTB_IDX_W_DEFAULT = 6;
    localparam int          FETCH_GROUP_BYTES = 16;

    // Tag field is sized for the smallest sensible index (pc[31:4] with zero
    // index bits), so the entry layout does not depend on BTB_IDX_W.
    localparam int          TAG_W             = 28;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [1:0]        slot;
        logic [29:0]       target;
        logic [1:0]        ctr;
    } btb_entry_t;

    typedef struct packed {
        logic              hit;
        logic [1:0]        slot;
        logic [1:0]        ctr;
        logic [29:0]       target;
    } btb_rd_t;

    // Two-bit saturating counter step.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        if (up) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/npc_gen_if.sv
// Fetch request channel from the PC generator into the IFU fetch buffer.
interface npc_gen_if;

    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [1:0]  cut_pos;
    logic        pred_taken;
    logic [31:0] pred_jump_target_pc;
    logic        ifu_ready;

    modport master (
        output fetch_valid,
        output fetch_pc,
        output cut_pos,
        output pred_taken,
        output pred_jump_target_pc,
        input  ifu_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        input  cut_pos,
        input  pred_taken,
        input  pred_jump_target_pc,
        output ifu_ready
    );

endinterface

// File: rtl/npc_btb.sv
// Direct-mapped group BTB: one combinational lookup port and one
// branch-resolution training port that writes on the clock edge.
module npc_btb
    import npc_gen_pkg::*;
#(
    parameter int BTB_IDX_W = BTB_IDX_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:4]  rd_grp,
    output btb_rd_t      rd,
    input  logic         upd_valid,
    input  logic [31:2]  upd_word,
    input  logic         upd_taken,
    input  logic [31:2]  upd_target
);

    localparam int ENTRIES = 1 << BTB_IDX_W;

    btb_entry_t                mem [ENTRIES];

    logic [BTB_IDX_W-1:0]      rd_idx;
    logic [TAG_W-1:0]          rd_tag;
    btb_entry_t                rd_entry;

    logic [BTB_IDX_W-1:0]      upd_idx;
    logic [TAG_W-1:0]          upd_tag;
    logic [1:0]                upd_slot;
    btb_entry_t                upd_entry;
    logic                      upd_hit;
    logic                      wr_en;
    btb_entry_t                wr_entry;

    assign rd_idx   = rd_grp[BTB_IDX_W+3:4];
    assign rd_tag   = TAG_W'(rd_grp >> BTB_IDX_W);
    assign upd_idx  = upd_word[BTB_IDX_W+3:4];
    assign upd_tag  = TAG_W'(upd_word[31:4] >> BTB_IDX_W);
    assign upd_slot = upd_word[3:2];

    // Lookup port: reads the array as it stands before this cycle's write.
    always_comb begin
        rd_entry  = mem[rd_idx];
        rd.hit    = rd_entry.valid && (rd_entry.tag == rd_tag);
        rd.slot   = rd_entry.slot;
        rd.ctr    = rd_entry.ctr;
        rd.target = rd_entry.target;
    end

    // Training: strengthen/weaken a matching slot, or allocate on a taken miss.
    always_comb begin
        upd_entry = mem[upd_idx];
        upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);
        wr_en     = 1'b0;
        wr_entry  = upd_entry;
        if (upd_valid) begin
            if (upd_hit && (upd_entry.slot == upd_slot)) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_step(upd_entry.ctr, upd_taken);
                if (upd_taken) begin
                    wr_entry.target = upd_target;
                end
            end else if (upd_taken) begin
                wr_en    = 1'b1;
                wr_entry = '{valid: 1'b1, tag: upd_tag, slot: upd_slot,
                             target: upd_target, ctr: 2'b10};
            end
        end
    end

    // Entry storage; reset invalidates every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[upd_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/npc_gen.sv
// Fetch-PC generator: picks the next 16-byte fetch group from redirect,
// BTB prediction or sequential increment and registers the fetch request.
module npc_gen
    import npc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BTB_IDX_W = BTB_IDX_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    npc_gen_if.master   fetch
);

    logic [31:0] npc_q;
    logic        valid_q;
    logic [31:0] pc_q;
    logic [1:0]  cut_q;
    logic        taken_q;
    logic [31:0] target_q;

    logic [31:0] lk_pc;
    logic [1:0]  lk_off;
    btb_rd_t     rd;
    logic        lk_taken;
    logic [2:0]  lk_count;
    logic [31:0] lk_next;
    logic [31:0] lk_target;
    logic        load;
    logic        unused_low_bits;

    assign unused_low_bits = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    npc_btb #(.BTB_IDX_W(BTB_IDX_W)) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_grp     (lk_pc[31:4]),
        .rd         (rd),
        .upd_valid  (upd_valid),
        .upd_word   (upd_pc[31:2]),
        .upd_taken  (upd_taken),
        .upd_target (upd_target[31:2])
    );

    // A single lookup port serves both the redirect address and the
    // sequential/predicted npc, since a redirect always wins.
    always_comb begin
        lk_pc     = redirect_valid ? {redirect_pc[31:2], 2'b00} : npc_q;
        lk_off    = lk_pc[3:2];
        lk_taken  = rd.hit && rd.ctr[1] && (rd.slot >= lk_off);
        lk_count  = lk_taken ? ({1'b0, rd.slot} - {1'b0, lk_off} + 3'd1)
                             : (3'd4 - {1'b0, lk_off});
        lk_target = lk_taken ? {rd.target, 2'b00} : 32'h0;
        lk_next   = lk_taken ? {rd.target, 2'b00}
                             : ({lk_pc[31:4], 4'h0} + 32'(FETCH_GROUP_BYTES));
        load      = redirect_valid || (!stall && (!valid_q || fetch.ifu_ready));
    end

    // Request registers: load on redirect or advance, otherwise hold bit-stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            npc_q    <= RESET_PC;
            valid_q  <= 1'b0;
            pc_q     <= 32'h0;
            cut_q    <= 2'b00;
            taken_q  <= 1'b0;
            target_q <= 32'h0;
        end else if (load) begin
            npc_q    <= lk_next;
            valid_q  <= 1'b1;
            pc_q     <= lk_pc;
            cut_q    <= lk_count[1:0];
            taken_q  <= lk_taken;
            target_q <= lk_target;
        end
    end

    assign fetch.fetch_valid         = valid_q;
    assign fetch.fetch_pc            = pc_q;
    assign fetch.cut_pos             = cut_q;
    assign fetch.pred_taken          = taken_q;
    assign fetch.pred_jump_target_pc = target_q;

endmodule
